fetch_pc: RTL and testbench
===========================

# fetch_pc

Fetch-stage PC holder and instruction-memory requester; it consumes the next-PC value produced by `npc` and returns `F_PC` to it. It owns the architectural fetch PC and issues one request per instruction to a variable-latency instruction memory. It presents one buffered instruction to the D stage with a valid flag, and honours pipeline stalls and flushes, including flushes that arrive while a fetch is outstanding.

## Interface
- `RESET_PC`, default `32'h0000_3000`: PC loaded on reset.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `stall` in 1: hazard-unit stall; D stage cannot accept an instruction.
- `npc_in` in 32: next PC from `npc` (either `F_PC+4` or a branch/jump target).
- `flush` in 1: discard the current fetch and restart at `flush_pc`.
- `flush_pc` in 32: restart address; valid only with `flush`.
- `imem_req` out 1: request strobe; accepted by memory in the same cycle.
- `imem_addr` out 32: request address.
- `imem_rvalid` in 1: response strobe, 1 or more cycles after the request.
- `imem_rdata` in 32: response instruction word.
- `F_PC` out 32: PC of the instruction being fetched or held; feeds `npc`.
- `F_instr` out 32: buffered instruction.
- `F_valid` out 1: `F_instr` is valid for D.
- `F_adel` out 1: fetch address error; see Configuration.

## Operation
- Registers: `pc_q`, `instr_q`, `adel_q`, and a 2-bit state in {REQ, WAIT, KILL, HAVE}.
- Outputs: `F_PC = pc_q`, `F_instr = instr_q`, `F_valid = (state == HAVE)`, `F_adel = adel_q`.
- REQ:
  - `imem_req=1`, `imem_addr=pc_q`; next state WAIT.
  - If `flush`: `imem_addr=flush_pc`, `pc_q<=flush_pc`, next state WAIT.
- WAIT: `imem_req=0`.
  - `imem_rvalid` and no `flush`: `instr_q<=imem_rdata`, next state HAVE.
  - `flush` and `imem_rvalid`: drop the data, `pc_q<=flush_pc`, next state REQ.
  - `flush` without `imem_rvalid`: `pc_q<=flush_pc`, next state KILL.
- KILL: `imem_req=0`.
  - On `imem_rvalid`: drop the data, next state REQ.
  - A further `flush` updates `pc_q` and stays in KILL.
- HAVE:
  - `flush` has priority: `pc_q<=flush_pc`, next state REQ. The held instruction is lost.
  - Else `!stall`: D consumes the instruction. Same cycle: `imem_req=1`, `imem_addr=npc_in`, `pc_q<=npc_in`, next state WAIT.
  - Else (`stall`): hold every register; `imem_req=0`.
- `imem_rvalid` in REQ or HAVE is a protocol violation and is ignored.
- `stall` is ignored outside HAVE. The memory request is never stalled.

## Timing
- Reset values: state=REQ, `pc_q=RESET_PC`, `instr_q=0`, `adel_q=0`, `F_valid=0`.
- `imem_req` is forced to 0 while `reset` is high.
- The first request is issued in the first cycle after `reset` deasserts.
- Request issued in cycle t, `imem_rvalid` in cycle t+k (k≥1): `F_valid=1` from cycle t+k+1.
- Back-to-back throughput with k=1 and no stall: one instruction every 2 cycles.
- Reset asserted mid-fetch: the outstanding response is abandoned; the memory is reset by the same signal.
- All flush redirections take effect at the next clock edge. `F_valid` is 0 in the cycle after a flush.

## Configuration
- `FETCH_ADEL_EN` defined:
  - In REQ, if the address to be requested has `[1:0]!=0` or lies outside `[0x3000, 0x6FFC]`, no request is issued.
  - Instead: `instr_q<=0` (nop), `adel_q<=1`, next state HAVE.
  - `adel_q` clears on any REQ or WAIT entry with a good address.
- Not defined:
  - `F_adel` is tied to 0.
  - Every address is requested unchanged.

## Test plan
- Reset release, memory latency 1 → `imem_addr=0x3000` on cycle 1; `F_valid=1` with `F_PC=0x3000` and `F_instr=rdata` on cycle 3.
- HAVE with `stall=1` for 3 cycles, then `npc_in=0x3004` → `F_instr` held for the 3 cycles; a request to `0x3004` is issued in the release cycle.
- Taken branch: `npc_in=0x3040` on consume → next `imem_addr=0x3040`, `F_PC=0x3040`.
- `flush` with `flush_pc=0x4180` in WAIT, memory latency 3 → state KILL; stale rdata dropped (`F_valid` stays 0); next request is to `0x4180`.
- `flush` and `imem_rvalid` in the same cycle → data dropped; REQ to `flush_pc` on the next cycle.
- With `FETCH_ADEL_EN`, `npc_in=0x3002` → no `imem_req`; `F_valid=1`, `F_instr=0`, `F_adel=1`. Without the macro → request to `0x3002` issued and `F_adel=0`.

Source files
------------

// File: rtl/fetch_pc.sv
// Fetch-stage PC register and instruction-memory requester with a one-entry instruction buffer.
// Optional fetch address-error trapping is enabled by defining FETCH_ADEL_EN.
module fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] npc_in,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_instr,
    output logic        F_valid,
    output logic        F_adel
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2,
        HAVE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    logic        want_issue;
    logic [31:0] issue_addr;
    logic        issue_bad;

    // A request leaves from REQ (at pc_q, or flush_pc when redirected) or from HAVE on consume.
    assign want_issue = (state_q == REQ) || ((state_q == HAVE) && !flush && !stall);
    assign issue_addr = (state_q == HAVE) ? npc_in : (flush ? flush_pc : pc_q);

`ifdef FETCH_ADEL_EN
    logic adel_q;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
    endfunction

    assign issue_bad = addr_bad(issue_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adel_q <= 1'b0;
        end else if (want_issue && issue_bad) begin
            adel_q <= 1'b1;
        end else if ((state_d == WAIT) || ((state_d == REQ) && !addr_bad(pc_d))) begin
            adel_q <= 1'b0;
        end
    end

    assign F_adel = adel_q;
`else
    assign issue_bad = 1'b0;
    assign F_adel    = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;

        case (state_q)
            WAIT: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = imem_rvalid ? REQ : KILL;
                end else if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = HAVE;
                end
            end
            KILL: begin
                // The response for the abandoned request must drain before a new one goes out.
                if (flush) begin
                    pc_d = flush_pc;
                end
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            HAVE: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = REQ;
                end
            end
            default: ;
        endcase

        if (want_issue) begin
            pc_d = issue_addr;
            if (issue_bad) begin
                instr_d = '0;
                state_d = HAVE;
            end else begin
                state_d = WAIT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req  = want_issue && !issue_bad && !reset;
    assign imem_addr = issue_addr;

    assign F_PC    = pc_q;
    assign F_instr = instr_q;
    assign F_valid = (state_q == HAVE);

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: table-driven fetch sequences plus hand-written flush/reset cases.
// Delivered instructions are pushed to a scoreboard when the memory response is driven.
module tb_fetch_pc;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] npc_in;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] F_PC;
    logic [31:0] F_instr;
    logic        F_valid;
    logic        F_adel;

    always #5 clk = ~clk;

    fetch_pc #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .npc_in      (npc_in),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .F_PC        (F_PC),
        .F_instr     (F_instr),
        .F_valid     (F_valid),
        .F_adel      (F_adel)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_t;

    typedef struct {
        int          stall_n;
        logic [31:0] npc;
        int          lat;
        logic [31:0] data;
    } vec_t;

    fetch_t sb[$];
    vec_t   vecs[5];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, return mid-cycle for sampling.
    task automatic cyc(input logic st, input logic [31:0] npc, input logic fl,
                       input logic [31:0] fpc, input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        stall       = st;
        npc_in      = npc;
        flush       = fl;
        flush_pc    = fpc;
        imem_rvalid = rv;
        imem_rdata  = rd;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b1, 32'hDEAD_BEE0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic respond(input logic [31:0] pc, input logic [31:0] data);
        cyc(1'b1, 32'hDEAD_BEE0, 1'b0, 32'h0, 1'b1, data);
        sb.push_back(fetch_t'{pc, data, 1'b0});
        check_bit("resp_req_low", imem_req, 1'b0);
        check_bit("resp_valid_low", F_valid, 1'b0);
    endtask

    task automatic check_have(input string tag);
        fetch_t f;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got F_valid=%b F_PC=%h", tag, F_valid, F_PC);
        end else begin
            f = sb.pop_front();
            check_bit({tag, "_valid"}, F_valid, 1'b1);
            check({tag, "_pc"}, F_PC, f.pc);
            check({tag, "_instr"}, F_instr, f.instr);
            check_bit({tag, "_adel"}, F_adel, f.adel);
        end
    endtask

    initial begin
        vecs[0] = '{3, 32'h0000_3004, 1, 32'h1111_0001};
        vecs[1] = '{0, 32'h0000_3040, 2, 32'h2222_0002};
        vecs[2] = '{0, 32'h0000_3044, 1, 32'h3333_0003};
        vecs[3] = '{0, 32'h0000_3048, 1, 32'h4444_0004};
        vecs[4] = '{1, 32'h0000_6FFC, 4, 32'h5555_0005};

        reset       = 1'b1;
        stall       = 1'b0;
        npc_in      = '0;
        flush       = 1'b0;
        flush_pc    = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        repeat (2) @(negedge clk);
        check_bit("rst_req", imem_req, 1'b0);
        check_bit("rst_valid", F_valid, 1'b0);
        check("rst_pc", F_PC, RESET_PC);
        check("rst_instr", F_instr, 32'h0);
        check_bit("rst_adel", F_adel, 1'b0);

        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_bit("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0000_3000);
        respond(32'h0000_3000, 32'hA000_0001);

        foreach (vecs[i]) begin
            for (int s = 0; s < vecs[i].stall_n; s++) begin
                // Stray response while holding must be ignored.
                cyc(1'b1, 32'hBAD0_0000, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
                check_bit("stall_req", imem_req, 1'b0);
                check_bit("stall_valid", F_valid, 1'b1);
                check("stall_instr", F_instr, sb[0].instr);
                check("stall_pc", F_PC, sb[0].pc);
            end
            cyc(1'b0, vecs[i].npc, 1'b0, 32'h0, 1'b0, 32'h0);
            check_have("consume");
            check_bit("issue_req", imem_req, 1'b1);
            check("issue_addr", imem_addr, vecs[i].npc);
            for (int w = 1; w < vecs[i].lat; w++) begin
                idle();
                check_bit("wait_req", imem_req, 1'b0);
                check_bit("wait_valid", F_valid, 1'b0);
            end
            respond(vecs[i].npc, vecs[i].data);
        end

        // Flush in WAIT, memory latency 3: stale data drains through KILL.
        cyc(1'b0, 32'h0000_3100, 1'b0, 32'h0, 1'b0, 32'h0);
        check_have("pre_kill");
        check("pre_kill_addr", imem_addr, 32'h0000_3100);
        idle();
        cyc(1'b1, 32'h0, 1'b1, 32'h0000_4180, 1'b0, 32'h0);
        check_bit("wflush_req", imem_req, 1'b0);
        check_bit("wflush_valid", F_valid, 1'b0);
        cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'hBAAD_F00D);
        check("kill_pc", F_PC, 32'h0000_4180);
        check_bit("kill_valid", F_valid, 1'b0);
        check_bit("kill_req", imem_req, 1'b0);
        idle();
        check_bit("kill_drop_valid", F_valid, 1'b0);
        check_bit("kill_rereq", imem_req, 1'b1);
        check("kill_readdr", imem_addr, 32'h0000_4180);
        respond(32'h0000_4180, 32'h6666_0006);

        // Flush and response in the same cycle.
        cyc(1'b0, 32'h0000_3200, 1'b0, 32'h0, 1'b0, 32'h0);
        check_have("pre_fr");
        check("pre_fr_addr", imem_addr, 32'h0000_3200);
        cyc(1'b1, 32'h0, 1'b1, 32'h0000_5000, 1'b1, 32'hBAAD_0001);
        check_bit("fr_req", imem_req, 1'b0);
        idle();
        check_bit("fr_valid", F_valid, 1'b0);
        check("fr_pc", F_PC, 32'h0000_5000);
        check_bit("fr_req2", imem_req, 1'b1);
        check("fr_addr", imem_addr, 32'h0000_5000);
        respond(32'h0000_5000, 32'h7777_0007);

        // Flush in HAVE beats consume, then a second flush lands in REQ.
        cyc(1'b0, 32'h0000_9990, 1'b1, 32'h0000_5800, 1'b0, 32'h0);
        check_have("have_flush");
        check_bit("hflush_req", imem_req, 1'b0);
        cyc(1'b1, 32'h0, 1'b1, 32'h0000_5900, 1'b0, 32'h0);
        check_bit("hflush_valid", F_valid, 1'b0);
        check("hflush_pc", F_PC, 32'h0000_5800);
        check_bit("rflush_req", imem_req, 1'b1);
        check("rflush_addr", imem_addr, 32'h0000_5900);
        respond(32'h0000_5900, 32'h8888_0008);

        // Misaligned next PC.
        cyc(1'b0, 32'h0000_3002, 1'b0, 32'h0, 1'b0, 32'h0);
        check_have("pre_adel");
`ifdef FETCH_ADEL_EN
        check_bit("adel_noreq", imem_req, 1'b0);
        sb.push_back(fetch_t'{32'h0000_3002, 32'h0, 1'b1});
`else
        check_bit("mis_req", imem_req, 1'b1);
        check("mis_addr", imem_addr, 32'h0000_3002);
        respond(32'h0000_3002, 32'h9999_0009);
`endif
        cyc(1'b0, 32'h0000_3008, 1'b0, 32'h0, 1'b0, 32'h0);
        check_have("adel");
        check_bit("post_adel_req", imem_req, 1'b1);
        check("post_adel_addr", imem_addr, 32'h0000_3008);
        respond(32'h0000_3008, 32'hAAAA_000A);

        // Reset while a fetch is outstanding.
        cyc(1'b0, 32'h0000_300C, 1'b0, 32'h0, 1'b0, 32'h0);
        check_have("pre_reset");
        idle();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_pc", F_PC, RESET_PC);
        check_bit("mid_rst_valid", F_valid, 1'b0);
        check_bit("mid_rst_req", imem_req, 1'b0);
        @(posedge clk);
        #1;
        check_bit("held_rst_req", imem_req, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_bit("rerst_req", imem_req, 1'b1);
        check("rerst_addr", imem_addr, RESET_PC);
        respond(RESET_PC, 32'hBBBB_000B);
        cyc(1'b0, 32'h0000_3004, 1'b0, 32'h0, 1'b0, 32'h0);
        check_have("post_reset");

        check("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
